aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter: NUM_ROUNDS, 10, number of cipher rounds; legal values 10, 12, 14.
REQ-002 SHALL have one clock and an asynchronous, active-low reset:
- i_clock  in  1  clock; all state updates on the rising edge
- i_reset_n  in  1  asynchronous reset, active-low
REQ-003 SHALL have the remaining ports:
- i_start  in  1  request to encrypt i_data
- i_abort  in  1  synchronous cancel of the current operation
- i_data  in  [0:127]  plaintext; byte k = bits [8k:8k+7]; state byte k is row k%4, column k/4
- i_round_key  in  [0:127]  round key for o_key_round; combinationally valid in the same cycle
- o_key_round  out  4  index of the round key requested
- o_sb_data  out  [0:127]  state presented to the shared SubBytes unit
- o_sb_active  out  1  SubBytes enable
- i_sb_data  in  [0:127]  SubBytes result
- o_busy  out  1  operation in progress
- o_done  out  1  one-cycle completion strobe
- o_data  out  [0:127]  ciphertext

Function
REQ-004 SHALL implement FSM states IDLE, SUB, ROUND, DONE, with a 4-bit round counter and a 128-bit state register.
REQ-005 IDLE SHALL drive o_key_round=0; on i_start=1 SHALL load state = i_data XOR i_round_key, set round=1, and go to SUB.
REQ-006 SUB SHALL last one cycle with o_sb_active=1 and o_sb_data=state, then go to ROUND.
REQ-007 The SubBytes unit SHALL register on the falling edge, so i_sb_data is valid at the next rising edge; no wait states.
REQ-008 ROUND SHALL drive o_key_round=round and load state = AddRoundKey(MixColumns(ShiftRows(i_sb_data)), i_round_key).
REQ-009 When round==NUM_ROUNDS, ROUND SHALL omit MixColumns.
REQ-010 ShiftRows SHALL rotate row r left by r bytes.
REQ-011 MixColumns SHALL use the GF(2^8) matrix [02 03 01 01] circulant with reduction polynomial 0x11B; xtime on an MSB-set byte SHALL XOR 0x1B.
REQ-012 Leaving ROUND, the FSM SHALL increment round and return to SUB if round<NUM_ROUNDS; otherwise it SHALL copy state to o_data and go to DONE.
REQ-013 DONE SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-014 Latency SHALL be exactly 2*NUM_ROUNDS rising edges from the edge that samples i_start to the first cycle with o_done=1 (20 for NUM_ROUNDS=10).
REQ-015 o_busy SHALL be 1 in SUB and ROUND and 0 in IDLE and DONE.
REQ-016 i_start SHALL be ignored outside IDLE; a start in the DONE cycle SHALL be dropped.
REQ-017 i_abort=1 in SUB or ROUND SHALL return the FSM to IDLE at the next edge, with no o_done and o_data unchanged.
REQ-018 i_abort SHALL have priority over all other transitions; i_abort and i_start together in IDLE SHALL leave the FSM in IDLE.
REQ-019 o_data SHALL hold its value from the DONE cycle until the next completed operation.
REQ-020 o_sb_active SHALL be 0 in every state except SUB.
REQ-021 o_key_round SHALL be 0 in DONE.

Reset
REQ-022 While i_reset_n=0, all registers SHALL clear asynchronously: FSM=IDLE, round=0, state=0, o_data=0, o_done=0, o_busy=0, o_sb_active=0, o_key_round=0.
REQ-023 Reset asserted mid-operation SHALL abandon the operation with no o_done.
REQ-024 The first i_start SHALL be accepted on the first rising edge after i_reset_n deasserts.

Verification
REQ-025 The bench SHALL cover FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c (expanded key table driven from o_key_round), plaintext 3243f6a8885a308d313198a2e0370734 -> o_data=3925841d02dc09fbdc118597196a0b32, with o_done exactly 20 edges after start.
REQ-026 The bench SHALL cover FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a; and App. C.3 with NUM_ROUNDS=14 -> 8ea2b7ca516745bfeafc49904b496089 after 28 edges.
REQ-027 The bench SHALL cover back-to-back operation: i_start held high continuously -> a new operation is accepted each IDLE cycle, o_done pulses every 22 cycles, and the start in the DONE cycle is dropped.
REQ-028 The bench SHALL cover abort: i_abort in round 5 -> IDLE next edge, no o_done, o_data keeps the previous ciphertext; a following start gives the correct result.
REQ-029 The bench SHALL cover asynchronous reset: i_reset_n low during round 3, asynchronous to the clock -> all outputs 0 immediately, no o_done; an App. B run after release passes.
REQ-030 The bench SHALL check as assertions on every cycle: o_sb_active only in SUB; o_done never two consecutive cycles; o_busy and o_done never both 1.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption round sequencer feeding a shared external SubBytes unit
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [0:127] i_data,
  input  logic [0:127] i_round_key,
  output logic [3:0]   o_key_round,
  output logic [0:127] o_sb_data,
  output logic         o_sb_active,
  input  logic [0:127] i_sb_data,
  output logic         o_busy,
  output logic         o_done,
  output logic [0:127] o_data
);
  typedef enum logic [1:0] {IDLE, SUB, ROUND, DONE} fsm_t;
  fsm_t fsm, fsm_nxt;
  logic [3:0] round, round_nxt;
  logic [0:127] st, st_nxt, data_nxt, sr, mc, rnd_out;
  logic last;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [0:31] mix_col(input logic [0:31] col);
    logic [7:0] a [4];
    logic [0:31] m;
    for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    return m;
  endfunction
  // state byte k sits at row k%4, column k/4; row r rotates left by r columns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[8*(r+4*c) +: 8] = i_sb_data[8*(r+4*((c+r)%4)) +: 8];
    end
    assign mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
  end
  assign last = round == 4'(NUM_ROUNDS);
  assign rnd_out = (last ? sr : mc) ^ i_round_key;
  assign o_key_round = fsm == ROUND ? round : 4'd0;
  assign o_sb_data = st;
  assign o_sb_active = fsm == SUB;
  assign o_busy = fsm == SUB || fsm == ROUND;
  assign o_done = fsm == DONE;
  always_comb begin
    fsm_nxt = fsm;
    round_nxt = round;
    st_nxt = st;
    data_nxt = o_data;
    if (i_abort) fsm_nxt = IDLE;
    else
      case (fsm)
        IDLE: if (i_start) begin
          fsm_nxt = SUB;
          round_nxt = 4'd1;
          st_nxt = i_data ^ i_round_key;
        end
        SUB: fsm_nxt = ROUND;
        ROUND: begin
          st_nxt = rnd_out;
          fsm_nxt = last ? DONE : SUB;
          round_nxt = last ? round : round + 4'd1;
          data_nxt = last ? rnd_out : o_data;
        end
        DONE: fsm_nxt = IDLE;
      endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      fsm <= IDLE;
      round <= '0;
      st <= '0;
      o_data <= '0;
    end else begin
      fsm <= fsm_nxt;
      round <= round_nxt;
      st <= st_nxt;
      o_data <= data_nxt;
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench comparing aes_round_ctrl (10 and 14 rounds) against a behavioural AES model
module tb_aes_round_ctrl;
  localparam int NR [2] = '{10, 14};
  localparam logic [0:127] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:255] C3_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] C3_CT    = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 0;
  logic rst_n = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start [2], abort [2], sb_active [2], busy [2], done [2], prev_done [2];
  logic [0:127] data [2], rkey [2], sb_data [2], sb_in [2], dout [2], last_ct [2];
  logic [3:0] key_round [2];
  logic [0:127] rk [2][16];
  logic [0:127] ks [16];
  logic [7:0] sbox [256];
  int lo [2], hi [2], idle_from [2];
  int checks = 0, passes = 0;

  typedef struct { int u; int due; logic [0:127] ct; } exp_t;
  exp_t sbq [$];

  assign rkey[0] = rk[0][key_round[0]];
  assign rkey[1] = rk[1][key_round[1]];

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
    .i_data(data[0]), .i_round_key(rkey[0]), .o_key_round(key_round[0]),
    .o_sb_data(sb_data[0]), .o_sb_active(sb_active[0]), .i_sb_data(sb_in[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_data(dout[0])
  );
  aes_round_ctrl #(.NUM_ROUNDS(14)) dut14 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
    .i_data(data[1]), .i_round_key(rkey[1]), .o_key_round(key_round[1]),
    .o_sb_data(sb_data[1]), .o_sb_active(sb_active[1]), .i_sb_data(sb_in[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_data(dout[1])
  );

  // GF(2^8) product: carry-less multiply, then reduce modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} >> (8 - n);
    return t[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] sub_bytes(input logic [0:127] v);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox[v[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input logic [0:255] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rcon;
    int nk;
    nk = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[32*i +: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) ks[r] = r <= nr ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [0:127] aes(input logic [0:127] pt, input int nr);
    logic [7:0] s [16], t [16];
    logic [0:127] r;
    for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ ks[0][8*k +: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox[s[k % 4 + 4 * ((k / 4 + k % 4) % 4)]];
      for (int k = 0; k < 16; k++)
        s[k] = (rd == nr ? t[k] : gmul(8'h02, t[k]) ^ gmul(8'h03, t[k - k % 4 + (k % 4 + 1) % 4])
               ^ t[k - k % 4 + (k % 4 + 2) % 4] ^ t[k - k % 4 + (k % 4 + 3) % 4]) ^ ks[rd][8*k +: 8];
    end
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s[k];
    return r;
  endfunction

  function automatic logic [0:127] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input int u, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, u, cyc, got, exp);
  endtask

  task automatic drop(input int u);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].u == u) begin
        sbq.delete(i);
        break;
      end
  endtask

  // drive one cycle of inputs and advance the reference model of what the DUT must do with them
  task automatic drive(input int u, input bit s, input bit a, input logic [0:127] pt,
                       input logic [0:255] key, input bit kn_ok, input logic [0:127] kn);
    start[u] = s;
    abort[u] = a;
    data[u] = pt;
    if (a && cyc >= lo[u] && cyc <= hi[u]) begin
      hi[u] = cyc;
      idle_from[u] = cyc + 1;
      drop(u);
    end else if (s && !a && cyc >= idle_from[u]) begin
      expand(key, NR[u]);
      for (int i = 0; i < 16; i++) rk[u][i] = ks[i];
      sbq.push_back('{u: u, due: cyc + 2 * NR[u] + 1, ct: kn_ok ? kn : aes(pt, NR[u])});
      lo[u] = cyc + 1;
      hi[u] = cyc + 2 * NR[u];
      idle_from[u] = cyc + 2 * NR[u] + 2;
    end
  endtask

  task automatic step(input int u, input bit s, input bit a, input logic [0:127] pt,
                      input logic [0:255] key, input bit kn_ok, input logic [0:127] kn);
    @(posedge clk);
    #1;
    drive(u, s, a, pt, key, kn_ok, kn);
  endtask

  task automatic idle(input int u, input int n);
    repeat (n) step(u, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic async_reset();
    rst_n = 0;
    for (int u = 0; u < 2; u++) begin
      hi[u] = -1;
      idle_from[u] = 0;
      last_ct[u] = '0;
    end
    sbq.delete();
  endtask

  task automatic reset_checks();
    for (int u = 0; u < 2; u++) begin
      chk("rst_ctrl", u, {busy[u], done[u], sb_active[u], key_round[u]}, 0);
      chk("rst_data", u, dout[u], 0);
      chk("rst_sb_data", u, sb_data[u], 0);
    end
  endtask

  // external SubBytes unit: captures on the falling edge of a SUB cycle
  always @(negedge clk)
    for (int u = 0; u < 2; u++)
      if (sb_active[u]) sb_in[u] <= sub_bytes(sb_data[u]);

  always @(negedge clk) begin
    int idx, ph;
    bit eb;
    for (int u = 0; u < 2; u++) begin
      idx = -1;
      for (int i = 0; i < sbq.size(); i++)
        if (idx < 0 && sbq[i].u == u) idx = i;
      if (idx >= 0 && sbq[idx].due == cyc) begin
        chk("done", u, done[u], 1);
        last_ct[u] = sbq[idx].ct;
        sbq.delete(idx);
      end else chk("spurious_done", u, done[u], 0);
      eb = cyc >= lo[u] && cyc <= hi[u];
      ph = cyc - lo[u];
      chk("data", u, dout[u], last_ct[u]);
      chk("busy", u, busy[u], eb);
      chk("sb_active", u, sb_active[u], eb && ph % 2 == 0);
      chk("key_round", u, key_round[u], eb && ph % 2 == 1 ? (ph + 1) / 2 : 0);
      chk("done_and_busy", u, done[u] & busy[u], 0);
      chk("done_twice", u, done[u] & prev_done[u], 0);
      prev_done[u] = done[u];
    end
  end

  initial begin
    build_sbox();
    for (int u = 0; u < 2; u++) begin
      start[u] = 0;
      abort[u] = 0;
      data[u] = '0;
      sb_in[u] = '0;
      lo[u] = 1;
      hi[u] = -1;
      idle_from[u] = 0;
      last_ct[u] = '0;
      prev_done[u] = 0;
      for (int i = 0; i < 16; i++) rk[u][i] = '0;
    end
    rst_n = 0;
    #1;
    reset_checks();
    repeat (4) @(posedge clk);
    #1;
    drive(0, 1, 0, APPB_PT, {APPB_KEY, 128'h0}, 1, APPB_CT);
    #2 rst_n = 1;
    idle(0, 25);
    step(0, 1, 0, C_PT, {C1_KEY, 128'h0}, 1, C1_CT);
    idle(0, 25);
    // abort during round 5, then a clean run
    step(0, 1, 0, r128(), {r128(), 128'h0}, 0, '0);
    idle(0, 9);
    step(0, 0, 1, '0, '0, 0, '0);
    idle(0, 3);
    step(0, 1, 0, r128(), {r128(), 128'h0}, 0, '0);
    idle(0, 25);
    repeat (110) step(0, 1, 0, r128(), {r128(), r128()}, 0, '0);
    idle(0, 25);
    // reset pulse in round 3, off the clock edges
    step(0, 1, 0, r128(), {r128(), 128'h0}, 0, '0);
    idle(0, 6);
    #2 async_reset();
    #1 reset_checks();
    #10 rst_n = 1;
    step(0, 1, 0, APPB_PT, {APPB_KEY, 128'h0}, 1, APPB_CT);
    idle(0, 25);
    step(1, 1, 0, C_PT, C3_KEY, 1, C3_CT);
    idle(1, 32);
    repeat (1500) step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, r128(), {r128(), r128()}, 0, '0);
    idle(0, 1);
    repeat (400) step(1, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, r128(), {r128(), r128()}, 0, '0);
    idle(1, 40);
    chk("drain", 0, sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
